pc_fetch_unit: RTL and testbench

Instruction-fetch front end of the single-issue MIPS pipeline: holds the program counter, issues word fetches on a req/ack instruction-memory port, and fills the IF/ID pipeline register. Its `if_id_pc4` output feeds the branch target adder's PC input. That adder's result comes back as `branch_target` to redirect the PC. It absorbs hazard stalls, branch/jump flushes, and variable memory latency.

---
 rtl/mips_pkg.sv | 15 +
 rtl/next_pc_sel.sv | 24 ++
 rtl/pc_fetch_unit.sv | 141 ++++++++++++++
 tb/tb_pc_fetch_unit.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS pipeline front end.
package mips_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StFetch,
        StHold,
        StDiscard
    } fetch_state_e;

    localparam logic [31:0] PC_STEP          = 32'd4;
    localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

endpackage

// File: rtl/next_pc_sel.sv
// Redirect decode: picks the branch or jump target and flags a redirect.
module next_pc_sel
    import mips_pkg::*;
(
    input  logic [31:0] pc4,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        jump,
    input  logic [25:0] jump_index,
    output logic        redirect,
    output logic [31:0] target
);

    always_comb begin
        redirect = branch_taken | jump;
        // Branch wins; both targets are forced onto a word boundary.
        if (branch_taken) begin
            target = branch_target & ~32'd3;
        end else begin
            target = (pc4 & 32'hF000_0000) | {4'b0000, jump_index, 2'b00};
        end
    end

endmodule

// File: rtl/pc_fetch_unit.sv
// Instruction fetch front end: PC, req/ack fetch port and the IF/ID register.
module pc_fetch_unit
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        jump,
    input  logic [25:0] jump_index,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] if_id_instr,
    output logic [31:0] if_id_pc4,
    output logic        if_id_valid
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  pend_pc_q, pend_pc_d;
    logic [31:0]  buf_instr_q, buf_instr_d;
    logic [31:0]  instr_q, instr_d;
    logic [31:0]  pc4_q, pc4_d;
    logic         valid_q, valid_d;

    logic         redirect;
    logic [31:0]  target;
    logic [31:0]  pc_plus4;

    next_pc_sel u_next_pc_sel (
        .pc4           (pc4_q),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .jump          (jump),
        .jump_index    (jump_index),
        .redirect      (redirect),
        .target        (target)
    );

    assign pc_plus4 = pc_q + PC_STEP;

    // Bus outputs come from registers only; a DISCARD keeps presenting the stale address.
    assign imem_req    = (state_q == StFetch) || (state_q == StDiscard);
    assign imem_addr   = pc_q;
    assign if_id_instr = instr_q;
    assign if_id_pc4   = pc4_q;
    assign if_id_valid = valid_q;

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        pend_pc_d   = pend_pc_q;
        buf_instr_d = buf_instr_q;
        instr_d     = instr_q;
        pc4_d       = pc4_q;
        valid_d     = valid_q;

        unique case (state_q)
            StIdle: begin
                state_d = StFetch;
                if (redirect) begin
                    pc_d = target;
                end
            end
            StFetch: begin
                if (imem_ack) begin
                    if (redirect) begin
                        pc_d    = target;
                        valid_d = 1'b0;
                    end else if (stall) begin
                        buf_instr_d = imem_rdata;
                        state_d     = StHold;
                    end else begin
                        instr_d = imem_rdata;
                        pc4_d   = pc_plus4;
                        valid_d = 1'b1;
                        pc_d    = pc_plus4;
                    end
                end else if (redirect) begin
                    pend_pc_d = target;
                    valid_d   = 1'b0;
                    state_d   = StDiscard;
                end else if (!stall) begin
                    valid_d = 1'b0;
                end
            end
            StHold: begin
                if (redirect) begin
                    pc_d    = target;
                    valid_d = 1'b0;
                    state_d = StFetch;
                end else if (!stall) begin
                    instr_d = buf_instr_q;
                    pc4_d   = pc_plus4;
                    valid_d = 1'b1;
                    pc_d    = pc_plus4;
                    state_d = StFetch;
                end
            end
            StDiscard: begin
                // Newest redirect wins, even one arriving with the stale ack.
                if (redirect) begin
                    pend_pc_d = target;
                end
                if (imem_ack) begin
                    pc_d    = pend_pc_d;
                    state_d = StFetch;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            pc_q        <= RESET_PC;
            pend_pc_q   <= RESET_PC;
            buf_instr_q <= NOP_INSTR;
            instr_q     <= NOP_INSTR;
            pc4_q       <= 32'h0;
            valid_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            pend_pc_q   <= pend_pc_d;
            buf_instr_q <= buf_instr_d;
            instr_q     <= instr_d;
            pc4_q       <= pc4_d;
            valid_q     <= valid_d;
        end
    end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Bench for pc_fetch_unit: directed vector table, reset corner case, random run vs model.
module tb_pc_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall = 1'b0;
    logic        branch_taken = 1'b0;
    logic [31:0] branch_target = '0;
    logic        jump = 1'b0;
    logic [25:0] jump_index = '0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic [31:0] if_id_instr;
    logic [31:0] if_id_pc4;
    logic        if_id_valid;

    pc_fetch_unit #(.RESET_PC(32'h0)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .stall         (stall),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .jump          (jump),
        .jump_index    (jump_index),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_ack      (imem_ack),
        .imem_rdata    (imem_rdata),
        .if_id_instr   (if_id_instr),
        .if_id_pc4     (if_id_pc4),
        .if_id_valid   (if_id_valid)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic chk_outs(input string tag, input logic er, input logic [31:0] ea,
                            input logic ev, input logic [31:0] ep4, input logic [31:0] ei);
        chk({tag, " imem_req"}, {31'b0, imem_req}, {31'b0, er});
        chk({tag, " imem_addr"}, imem_addr, ea);
        chk({tag, " if_id_valid"}, {31'b0, if_id_valid}, {31'b0, ev});
        chk({tag, " if_id_pc4"}, if_id_pc4, ep4);
        chk({tag, " if_id_instr"}, if_id_instr, ei);
    endtask

    task automatic drive(input logic st, input logic br, input logic [31:0] bt, input logic jp,
                         input logic [25:0] ji, input logic ack, input logic [31:0] rd);
        stall = st; branch_taken = br; branch_target = bt; jump = jp;
        jump_index = ji; imem_ack = ack; imem_rdata = rd;
    endtask

    // Directed vectors: inputs for one cycle, then outputs expected after that edge.
    typedef struct {
        logic        st, br, jp, ack;
        logic [31:0] bt, rd;
        logic [25:0] ji;
        logic        er, ev;
        logic [31:0] ea, ep4, ei;
    } vec_t;

    function automatic vec_t mk(input logic st, input logic br, input logic [31:0] bt,
                                input logic jp, input logic [25:0] ji, input logic ack,
                                input logic [31:0] rd, input logic er, input logic [31:0] ea,
                                input logic ev, input logic [31:0] ep4, input logic [31:0] ei);
        vec_t v;
        v.st = st; v.br = br; v.bt = bt; v.jp = jp; v.ji = ji; v.ack = ack; v.rd = rd;
        v.er = er; v.ea = ea; v.ev = ev; v.ep4 = ep4; v.ei = ei;
        return v;
    endfunction

    vec_t vecs[29];

    // Reference model: what the front end holds, not how it is encoded.
    logic        m_started, m_have_buf, m_dropping, m_valid;
    logic [31:0] m_pc, m_pend, m_buf, m_instr, m_pc4;
    int          lat_left;

    task automatic model_reset();
        m_started = 0; m_have_buf = 0; m_dropping = 0; m_valid = 0;
        m_pc = 0; m_pend = 0; m_buf = 0; m_instr = 0; m_pc4 = 0;
        lat_left = -1;
    endtask

    function automatic logic m_req();
        return m_started && !m_have_buf;
    endfunction

    task automatic model_step(input logic st, input logic br, input logic [31:0] bt,
                              input logic jp, input logic [25:0] ji, input logic ack,
                              input logic [31:0] rd);
        logic [31:0] tgt;
        logic        redir;
        redir = br || jp;
        tgt = br ? (bt - (bt % 4)) : ((m_pc4 / 32'h1000_0000) * 32'h1000_0000 + ji * 4);
        if (!m_started) begin
            m_started = 1;
            if (redir) m_pc = tgt;
        end else if (m_dropping) begin
            if (redir) m_pend = tgt;
            if (ack) begin
                m_pc = m_pend;
                m_dropping = 0;
            end
        end else if (m_have_buf) begin
            if (redir) begin
                m_pc = tgt; m_valid = 0; m_have_buf = 0;
            end else if (!st) begin
                m_instr = m_buf; m_pc4 = m_pc + 4; m_valid = 1; m_pc = m_pc + 4;
                m_have_buf = 0;
            end
        end else if (ack) begin
            if (redir) begin
                m_pc = tgt; m_valid = 0;
            end else if (st) begin
                m_buf = rd; m_have_buf = 1;
            end else begin
                m_instr = rd; m_pc4 = m_pc + 4; m_valid = 1; m_pc = m_pc + 4;
            end
        end else if (redir) begin
            m_pend = tgt; m_dropping = 1; m_valid = 0;
        end else if (!st) begin
            m_valid = 0;
        end
    endtask

    initial begin
        vecs[0]  = mk(0, 0, 0, 0, 0, 0, 0, 1, 32'h0, 0, 32'h0, 32'h0);
        vecs[1]  = mk(0, 0, 0, 0, 0, 1, 32'hC0DE0000, 1, 32'h4, 1, 32'h4, 32'hC0DE0000);
        vecs[2]  = mk(0, 0, 0, 0, 0, 1, 32'hC0DE0004, 1, 32'h8, 1, 32'h8, 32'hC0DE0004);
        vecs[3]  = mk(1, 0, 0, 0, 0, 1, 32'hC0DE0008, 0, 32'h8, 1, 32'h8, 32'hC0DE0004);
        vecs[4]  = mk(1, 0, 0, 0, 0, 0, 0, 0, 32'h8, 1, 32'h8, 32'hC0DE0004);
        vecs[5]  = mk(1, 0, 0, 0, 0, 1, 32'hDEADBEEF, 0, 32'h8, 1, 32'h8, 32'hC0DE0004);
        vecs[6]  = mk(0, 0, 0, 0, 0, 0, 0, 1, 32'hC, 1, 32'hC, 32'hC0DE0008);
        vecs[7]  = mk(0, 0, 0, 0, 0, 1, 32'hC0DE000C, 1, 32'h10, 1, 32'h10, 32'hC0DE000C);
        vecs[8]  = mk(0, 1, 32'h40, 0, 0, 1, 32'hC0DE0010, 1, 32'h40, 0, 32'h10, 32'hC0DE000C);
        vecs[9]  = mk(0, 0, 0, 0, 0, 1, 32'hC0DE0040, 1, 32'h44, 1, 32'h44, 32'hC0DE0040);
        vecs[10] = mk(0, 1, 32'h83, 1, 26'h3FFFFFF, 0, 0, 1, 32'h44, 0, 32'h44, 32'hC0DE0040);
        vecs[11] = mk(0, 1, 32'hC0, 0, 0, 0, 0, 1, 32'h44, 0, 32'h44, 32'hC0DE0040);
        vecs[12] = mk(0, 0, 0, 0, 0, 1, 32'hBAD0BAD0, 1, 32'hC0, 0, 32'h44, 32'hC0DE0040);
        vecs[13] = mk(0, 1, 32'h80, 1, 26'h3FFFFFF, 1, 32'hC0DE00C0,
                      1, 32'h80, 0, 32'h44, 32'hC0DE0040);
        vecs[14] = mk(0, 0, 0, 0, 0, 1, 32'hC0DE0080, 1, 32'h84, 1, 32'h84, 32'hC0DE0080);
        vecs[15] = mk(0, 1, 32'h1000_0004, 0, 0, 1, 32'hC0DE0084,
                      1, 32'h1000_0004, 0, 32'h84, 32'hC0DE0080);
        vecs[16] = mk(0, 0, 0, 0, 0, 1, 32'h12345678,
                      1, 32'h1000_0008, 1, 32'h1000_0008, 32'h12345678);
        vecs[17] = mk(0, 0, 0, 1, 26'h10, 0, 0, 1, 32'h1000_0008, 0, 32'h1000_0008, 32'h12345678);
        vecs[18] = mk(0, 0, 0, 0, 0, 0, 0, 1, 32'h1000_0008, 0, 32'h1000_0008, 32'h12345678);
        vecs[19] = mk(0, 0, 0, 0, 0, 1, 32'hBAD0BAD0,
                      1, 32'h1000_0040, 0, 32'h1000_0008, 32'h12345678);
        vecs[20] = mk(0, 0, 0, 0, 0, 1, 32'h0000ABCD,
                      1, 32'h1000_0044, 1, 32'h1000_0044, 32'h0000ABCD);
        vecs[21] = mk(0, 1, 32'hFFFF_FFFC, 0, 0, 1, 32'h11111111,
                      1, 32'hFFFF_FFFC, 0, 32'h1000_0044, 32'h0000ABCD);
        vecs[22] = mk(0, 0, 0, 0, 0, 1, 32'h22222222, 1, 32'h0, 1, 32'h0, 32'h22222222);
        vecs[23] = mk(1, 0, 0, 0, 0, 0, 0, 1, 32'h0, 1, 32'h0, 32'h22222222);
        vecs[24] = mk(0, 0, 0, 0, 0, 0, 0, 1, 32'h0, 0, 32'h0, 32'h22222222);
        vecs[25] = mk(0, 0, 0, 0, 0, 1, 32'h33333333, 1, 32'h4, 1, 32'h4, 32'h33333333);
        vecs[26] = mk(1, 0, 0, 0, 0, 1, 32'h44444444, 0, 32'h4, 1, 32'h4, 32'h33333333);
        vecs[27] = mk(1, 1, 32'h200, 0, 0, 0, 0, 1, 32'h200, 0, 32'h4, 32'h33333333);
        vecs[28] = mk(0, 0, 0, 1, 26'h123, 0, 0, 1, 32'h200, 0, 32'h4, 32'h33333333);

        // Reset values.
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk_outs("reset", 0, 32'h0, 0, 32'h0, 32'h0);
        rst_n = 1'b1;

        for (int i = 0; i < 29; i++) begin
            drive(vecs[i].st, vecs[i].br, vecs[i].bt, vecs[i].jp, vecs[i].ji,
                  vecs[i].ack, vecs[i].rd);
            @(negedge clk);
            chk_outs($sformatf("row%0d", i), vecs[i].er, vecs[i].ea, vecs[i].ev,
                     vecs[i].ep4, vecs[i].ei);
        end

        // Asynchronous reset while a stale request is outstanding; the late ack is ignored.
        drive(0, 0, 0, 0, 0, 1, 32'h55555555);
        #2 rst_n = 1'b0;
        #1 chk_outs("async_rst", 0, 32'h0, 0, 32'h0, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk_outs("post_rst_idle", 1, 32'h0, 0, 32'h0, 32'h0);
        drive(0, 0, 0, 0, 0, 1, 32'h66666666);
        @(negedge clk);
        chk_outs("post_rst_fetch", 1, 32'h4, 1, 32'h4, 32'h66666666);

        // Random traffic against the model, with a variable-latency memory.
        drive(0, 0, 0, 0, 0, 0, 0);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        for (int c = 0; c < 3000; c++) begin
            logic        st, br, jp, ack;
            logic [31:0] bt, rd;
            logic [25:0] ji;
            chk_outs($sformatf("rand%0d", c), m_req(), m_pc, m_valid, m_pc4, m_instr);
            st = ($urandom_range(0, 3) == 0);
            br = ($urandom_range(0, 9) == 0);
            jp = ($urandom_range(0, 9) == 0);
            bt = $urandom;
            ji = 26'($urandom);
            rd = $urandom;
            if (m_req()) begin
                if (lat_left < 0) lat_left = $urandom_range(0, 3);
                ack = (lat_left == 0);
                lat_left = ack ? -1 : lat_left - 1;
            end else begin
                ack = ($urandom_range(0, 1) == 1);
            end
            drive(st, br, bt, jp, ji, ack, rd);
            model_step(st, br, bt, jp, ji, ack, rd);
            @(negedge clk);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
